// File: rtl/apb_master_arb.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_arb
//  Purpose  : Two-port APB master. Round-robin arbitration between two
//             req/ack requesters, APB SETUP/ACCESS sequencing, bounded
//             PREADY wait with timeout abort, and per-port read data and
//             status return.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W   APB address width
//    DATA_W   APB data width
//    TMO_CYC  ACCESS cycles without PREADY before abort (0 = wait forever)
//  Ports
//    iClk, iRst                 clock (rising edge), sync active-high reset
//    iReqN/iWrN/iAddrN/iWdataN  requester N transfer request (N = 0, 1)
//    oAckN/oErrN/oRdataN        requester N completion pulse, timeout flag,
//                               read data (held until the next ack)
//    oPsel/oPenable/oPwrite     APB control
//    oPaddr/oPwdata             APB address / write data
//    iPrdata/iPready            APB read data / ready from the slave
// ============================================================================
module apb_master_arb #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 16
) (
  input  logic              iClk,
  input  logic              iRst,

  input  logic              iReq0,
  input  logic              iWr0,
  input  logic [ADDR_W-1:0] iAddr0,
  input  logic [DATA_W-1:0] iWdata0,
  output logic              oAck0,
  output logic              oErr0,
  output logic [DATA_W-1:0] oRdata0,

  input  logic              iReq1,
  input  logic              iWr1,
  input  logic [ADDR_W-1:0] iAddr1,
  input  logic [DATA_W-1:0] iWdata1,
  output logic              oAck1,
  output logic              oErr1,
  output logic [DATA_W-1:0] oRdata1,

  output logic              oPsel,
  output logic              oPenable,
  output logic              oPwrite,
  output logic [ADDR_W-1:0] oPaddr,
  output logic [DATA_W-1:0] oPwdata,
  input  logic [DATA_W-1:0] iPrdata,
  input  logic              iPready
);

  // Wait counter only has to reach TMO_CYC-1; keep at least one bit so the
  // declaration stays legal when the timeout is disabled or trivially small.
  localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYC > 0) ? (TMO_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;   // port granted most recently
  logic              cur_port;     // port owning the transfer in flight
  logic [CNT_W-1:0]  wait_cnt;     // ACCESS cycles spent without PREADY

  logic              elig0;
  logic              elig1;
  logic              grant_valid;
  logic              grant_port;
  logic              grant_wr;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;
  logic              tmo_hit;

  // --------------------------------------------------------------------------
  // Arbitration. A requester whose ack is on the wire this cycle still has
  // its request asserted (it only reacts to the ack at the next edge), so it
  // is masked out to avoid granting the finished transfer a second time.
  // --------------------------------------------------------------------------
  always_comb begin
    elig0       = iReq0 & ~oAck0;
    elig1       = iReq1 & ~oAck1;
    grant_valid = elig0 | elig1;

    grant_port = 1'b0;
    if (elig0 && elig1) begin
      grant_port = ~last_grant;     // tie: the port that did not win last
    end else if (elig1) begin
      grant_port = 1'b1;
    end

    grant_wr    = grant_port ? iWr1    : iWr0;
    grant_addr  = grant_port ? iAddr1  : iAddr0;
    grant_wdata = grant_port ? iWdata1 : iWdata0;

    tmo_hit = (TMO_CYC != 0) && (wait_cnt == TMO_LAST);
  end

  // --------------------------------------------------------------------------
  // Transfer sequencer with registered APB and requester outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      last_grant <= 1'b1;           // port 0 wins the first tie
      cur_port   <= 1'b0;
      wait_cnt   <= '0;
      oPsel      <= 1'b0;
      oPenable   <= 1'b0;
      oPwrite    <= 1'b0;
      oPaddr     <= '0;
      oPwdata    <= '0;
      oAck0      <= 1'b0;
      oErr0      <= 1'b0;
      oRdata0    <= '0;
      oAck1      <= 1'b0;
      oErr1      <= 1'b0;
      oRdata1    <= '0;
    end else begin
      // Completion strobes are single-cycle pulses.
      oAck0 <= 1'b0;
      oErr0 <= 1'b0;
      oAck1 <= 1'b0;
      oErr1 <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            state      <= SETUP;
            cur_port   <= grant_port;
            last_grant <= grant_port;
            oPsel      <= 1'b1;
            oPenable   <= 1'b0;
            // Transfer attributes are captured once here; later requester
            // changes have no effect on the transfer in flight.
            oPwrite    <= grant_wr;
            oPaddr     <= grant_addr;
            oPwdata    <= grant_wdata;
          end
        end

        SETUP: begin
          state    <= ACCESS;
          oPenable <= 1'b1;
          wait_cnt <= '0;
        end

        ACCESS: begin
          if (iPready) begin
            state    <= IDLE;
            oPsel    <= 1'b0;
            oPenable <= 1'b0;
            if (cur_port == 1'b0) begin
              oAck0 <= 1'b1;
              if (!oPwrite) begin
                oRdata0 <= iPrdata;
              end
            end else begin
              oAck1 <= 1'b1;
              if (!oPwrite) begin
                oRdata1 <= iPrdata;
              end
            end
          end else if (tmo_hit) begin
            // Slave never answered: abort and report the error.
            state    <= IDLE;
            oPsel    <= 1'b0;
            oPenable <= 1'b0;
            if (cur_port == 1'b0) begin
              oAck0   <= 1'b1;
              oErr0   <= 1'b1;
              oRdata0 <= '0;
            end else begin
              oAck1   <= 1'b1;
              oErr1   <= 1'b1;
              oRdata1 <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end

        default: begin
          state    <= IDLE;
          oPsel    <= 1'b0;
          oPenable <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_arb
//  Purpose  : Self-checking bench for apb_master_arb: directed vector table,
//             hand-written multi-cycle sequences (round robin, timeout,
//             reset mid-transfer) and randomized traffic against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_arb;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, wr0, req1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, err0, ack1, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          psel, penable, pwrite, pready;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  always #5 clk = ~clk;

  apb_master_arb #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
    .iClk(clk), .iRst(rst),
    .iReq0(req0), .iWr0(wr0), .iAddr0(addr0), .iWdata0(wdata0),
    .oAck0(ack0), .oErr0(err0), .oRdata0(rdata0),
    .iReq1(req1), .iWr1(wr1), .iAddr1(addr1), .iWdata1(wdata1),
    .oAck1(ack1), .oErr1(err1), .oRdata1(rdata1),
    .oPsel(psel), .oPenable(penable), .oPwrite(pwrite),
    .oPaddr(paddr), .oPwdata(pwdata), .iPrdata(prdata), .iPready(pready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: one transfer at a time, tracked by its age in cycles
  // since the grant (1 = setup cycle, 2.. = access cycles).
  // --------------------------------------------------------------------------
  logic          m_psel, m_pen, m_pwrite;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata;
  logic [1:0]    m_ack, m_err;
  logic [DW-1:0] m_rdata [2];
  bit            m_busy;
  int            m_age, m_port, m_last;

  task automatic model_edge();
    bit e0, e1;
    int g;
    if (rst) begin
      m_psel = 1'b0; m_pen = 1'b0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
      m_ack = '0; m_err = '0; m_rdata[0] = '0; m_rdata[1] = '0;
      m_busy = 0; m_age = 0; m_port = 0; m_last = 1;
    end else begin
      e0 = req0 && !m_ack[0];
      e1 = req1 && !m_ack[1];
      m_ack = '0;
      m_err = '0;
      if (!m_busy) begin
        if (e0 || e1) begin
          g = (e0 && e1) ? (1 - m_last) : (e0 ? 0 : 1);
          m_busy = 1; m_age = 1; m_port = g; m_last = g;
          m_psel = 1'b1; m_pen = 1'b0;
          m_pwrite = (g == 1) ? wr1 : wr0;
          m_paddr  = (g == 1) ? addr1 : addr0;
          m_pwdata = (g == 1) ? wdata1 : wdata0;
        end
      end else if (m_age == 1) begin
        m_age = 2;
        m_pen = 1'b1;
      end else begin
        // m_age-1 is the number of access cycles including this one
        if (pready) begin
          m_busy = 0; m_psel = 1'b0; m_pen = 1'b0;
          m_ack[m_port] = 1'b1;
          if (!m_pwrite) m_rdata[m_port] = prdata;
        end else if (TMO != 0 && (m_age - 1) == TMO) begin
          m_busy = 0; m_psel = 1'b0; m_pen = 1'b0;
          m_ack[m_port] = 1'b1;
          m_err[m_port] = 1'b1;
          m_rdata[m_port] = '0;
        end else begin
          m_age++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic compare_model();
    chk("rnd_psel",   psel,    m_psel);
    chk("rnd_pen",    penable, m_pen);
    chk("rnd_pwrite", pwrite,  m_pwrite);
    chk("rnd_paddr",  paddr,   m_paddr);
    chk("rnd_pwdata", pwdata,  m_pwdata);
    chk("rnd_ack0",   ack0,    m_ack[0]);
    chk("rnd_err0",   err0,    m_err[0]);
    chk("rnd_ack1",   ack1,    m_ack[1]);
    chk("rnd_err1",   err1,    m_err[1]);
    chk("rnd_rdata0", rdata0,  m_rdata[0]);
    chk("rnd_rdata1", rdata1,  m_rdata[1]);
  endtask

  task automatic wait_ack(input int port, input int max_cyc, output int cyc, output bit got);
    got = 0;
    cyc = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      step();
      if ((port == 0 && ack0 === 1'b1) || (port == 1 && ack1 === 1'b1)) begin
        got = 1;
        cyc = c;
        break;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic          rst, req0, wr0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1, wr1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          x_psel, x_pen, x_pwrite;
    logic [AW-1:0] x_paddr;
    logic [DW-1:0] x_pwdata;
    logic          x_ack0, x_err0, x_ack1, x_err1;
    logic [DW-1:0] x_rdata0, x_rdata1;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  int  cyc, acc;
  bit  got, stall;
  int  ack_cyc[$];
  int  ack_port[$];
  int  grant_port[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rst,req0,wr0,addr0,wdata0, req1,wr1,addr1,wdata1, pready,prdata |
    // psel,pen,pwrite,paddr,pwdata, ack0,err0,ack1,err1, rdata0,rdata1
    tbl[0]  = '{1'b1,1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        1'b0,32'h0,
                1'b0,1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
    tbl[1]  = '{1'b0,1'b1,1'b1,16'h0004,32'hDEADBEEF, 1'b0,1'b0,16'h0000,32'h0,        1'b1,32'h0,
                1'b1,1'b0,1'b1,16'h0004,32'hDEADBEEF, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
    tbl[2]  = '{1'b0,1'b1,1'b1,16'h0008,32'hDEADBEEF, 1'b0,1'b0,16'h0000,32'h0,        1'b1,32'h0,
                1'b1,1'b1,1'b1,16'h0004,32'hDEADBEEF, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
    tbl[3]  = '{1'b0,1'b1,1'b1,16'h0008,32'hDEADBEEF, 1'b0,1'b0,16'h0000,32'h0,        1'b1,32'hFFFFFFFF,
                1'b0,1'b0,1'b1,16'h0004,32'hDEADBEEF, 1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0};
    tbl[4]  = '{1'b0,1'b1,1'b1,16'h0008,32'hDEADBEEF, 1'b0,1'b0,16'h0000,32'h0,        1'b1,32'hFFFFFFFF,
                1'b0,1'b0,1'b1,16'h0004,32'hDEADBEEF, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
    tbl[5]  = '{1'b0,1'b0,1'b0,16'h0008,32'h0,        1'b1,1'b0,16'h0010,32'h55AA55AA, 1'b0,32'h0,
                1'b1,1'b0,1'b0,16'h0010,32'h55AA55AA, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
    tbl[6]  = '{1'b0,1'b0,1'b0,16'h0008,32'h0,        1'b1,1'b0,16'h0010,32'h55AA55AA, 1'b0,32'h0,
                1'b1,1'b1,1'b0,16'h0010,32'h55AA55AA, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
    tbl[7]  = '{1'b0,1'b0,1'b0,16'h0008,32'h0,        1'b1,1'b0,16'h0010,32'h55AA55AA, 1'b0,32'h0,
                1'b1,1'b1,1'b0,16'h0010,32'h55AA55AA, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
    tbl[8]  = '{1'b0,1'b0,1'b0,16'h0008,32'h0,        1'b1,1'b0,16'h0020,32'h55AA55AA, 1'b0,32'h0,
                1'b1,1'b1,1'b0,16'h0010,32'h55AA55AA, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
    tbl[9]  = '{1'b0,1'b0,1'b0,16'h0008,32'h0,        1'b1,1'b0,16'h0020,32'h55AA55AA, 1'b1,32'h12345678,
                1'b0,1'b0,1'b0,16'h0010,32'h55AA55AA, 1'b0,1'b0,1'b1,1'b0, 32'h0,32'h12345678};
    tbl[10] = '{1'b0,1'b0,1'b0,16'h0008,32'h0,        1'b1,1'b0,16'h0020,32'h55AA55AA, 1'b1,32'h0,
                1'b0,1'b0,1'b0,16'h0010,32'h55AA55AA, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h12345678};
    tbl[11] = '{1'b0,1'b0,1'b0,16'h0008,32'h0,        1'b0,1'b0,16'h0020,32'h55AA55AA, 1'b1,32'h0,
                1'b0,1'b0,1'b0,16'h0010,32'h55AA55AA, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h12345678};

    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst; req0 = tbl[i].req0; wr0 = tbl[i].wr0; addr0 = tbl[i].addr0;
      wdata0 = tbl[i].wdata0; req1 = tbl[i].req1; wr1 = tbl[i].wr1; addr1 = tbl[i].addr1;
      wdata1 = tbl[i].wdata1; pready = tbl[i].pready; prdata = tbl[i].prdata;
      step();
      chk($sformatf("vec%0d_psel", i),   psel,    tbl[i].x_psel);
      chk($sformatf("vec%0d_pen", i),    penable, tbl[i].x_pen);
      chk($sformatf("vec%0d_pwrite", i), pwrite,  tbl[i].x_pwrite);
      chk($sformatf("vec%0d_paddr", i),  paddr,   tbl[i].x_paddr);
      chk($sformatf("vec%0d_pwdata", i), pwdata,  tbl[i].x_pwdata);
      chk($sformatf("vec%0d_ack0", i),   ack0,    tbl[i].x_ack0);
      chk($sformatf("vec%0d_err0", i),   err0,    tbl[i].x_err0);
      chk($sformatf("vec%0d_ack1", i),   ack1,    tbl[i].x_ack1);
      chk($sformatf("vec%0d_err1", i),   err1,    tbl[i].x_err1);
      chk($sformatf("vec%0d_rdata0", i), rdata0,  tbl[i].x_rdata0);
      chk($sformatf("vec%0d_rdata1", i), rdata1,  tbl[i].x_rdata1);
    end

    // ---------------- round robin, both requesting continuously ------------
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; step();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; wr0 = 1'b1; wr1 = 1'b1;
    addr0 = 16'h0100; addr1 = 16'h0200; pready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      step();
      if (ack0 === 1'b1) begin ack_cyc.push_back(c); ack_port.push_back(0); end
      if (ack1 === 1'b1) begin ack_cyc.push_back(c); ack_port.push_back(1); end
      if (psel === 1'b1 && penable === 1'b0)
        grant_port.push_back((paddr == 16'h0200) ? 1 : 0);
    end
    chk("rr_ack_count", ack_cyc.size(), 4);
    for (int i = 0; i < 4 && i < ack_cyc.size(); i++) begin
      chk($sformatf("rr_ack%0d_port", i),  ack_port[i], i % 2);
      chk($sformatf("rr_ack%0d_cycle", i), ack_cyc[i],  2 + 3 * i);
    end
    chk("rr_grant_count", grant_port.size(), 5);
    for (int i = 0; i < 5 && i < grant_port.size(); i++)
      chk($sformatf("rr_grant%0d_port", i), grant_port[i], i % 2);

    // ---------------- read, then timeout, then normal transfer -------------
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; step();
    rst = 1'b0; req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0030;
    prdata = 32'hCAFEF00D; pready = 1'b1;
    wait_ack(0, 10, cyc, got);
    chk("rd_ack_seen", got, 1);
    chk("rd_latency", cyc, 3);
    chk("rd_data", rdata0, 32'hCAFEF00D);
    req0 = 1'b0; step();

    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0034; pready = 1'b0;
    acc = 0; got = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (psel === 1'b1 && penable === 1'b1) acc++;
      if (ack0 === 1'b1) begin got = 1; break; end
    end
    chk("tmo_ack_seen", got, 1);
    chk("tmo_access_cycles", acc, TMO);
    chk("tmo_err", err0, 1);
    chk("tmo_rdata", rdata0, 0);
    chk("tmo_psel", psel, 0);
    req0 = 1'b0; step();
    chk("tmo_err_pulse", err0, 0);

    req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0038; wdata0 = 32'h0BADCAFE; pready = 1'b1;
    wait_ack(0, 10, cyc, got);
    chk("post_tmo_ack_seen", got, 1);
    chk("post_tmo_latency", cyc, 3);
    chk("post_tmo_err", err0, 0);
    chk("post_tmo_paddr", paddr, 16'h0038);
    chk("post_tmo_pwdata", pwdata, 32'h0BADCAFE);
    req0 = 1'b0; step();

    // ---------------- reset during ACCESS ----------------------------------
    req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0040; wdata0 = 32'h11111111; pready = 1'b0;
    step(); step();
    chk("mid_in_access", {psel, penable}, 2'b11);
    rst = 1'b1; req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0050; step();
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_pen", penable, 0);
    chk("mid_rst_ack0", ack0, 0);
    chk("mid_rst_err0", err0, 0);
    rst = 1'b0; pready = 1'b1; step();
    chk("mid_regrant_psel", {psel, penable}, 2'b10);
    chk("mid_regrant_paddr", paddr, 16'h0040);
    step(); step();
    chk("mid_regrant_ack0", ack0, 1);
    chk("mid_regrant_ack1", ack1, 0);

    // ---------------- randomized traffic vs reference model ----------------
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; step();
    rst = 1'b0; stall = 0;
    for (int c = 0; c < 800 && errors <= 30; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (!req0 || m_ack[0]) begin
        req0 = ($urandom_range(0, 2) == 0);
        wr0 = 1'($urandom_range(0, 1)); addr0 = AW'($urandom); wdata0 = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        wr0 = 1'($urandom_range(0, 1)); addr0 = AW'($urandom); wdata0 = $urandom;
      end
      if (!req1 || m_ack[1]) begin
        req1 = ($urandom_range(0, 2) == 0);
        wr1 = 1'($urandom_range(0, 1)); addr1 = AW'($urandom); wdata1 = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        wr1 = 1'($urandom_range(0, 1)); addr1 = AW'($urandom); wdata1 = $urandom;
      end
      if ($urandom_range(0, 39) == 0) stall = !stall;
      pready = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
      prdata = $urandom;
      step();
      compare_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
